// File: rtl/wb_mux_pipe_if.sv
// rtl/wb_mux_pipe_if.sv - writeback select bus: sources, select, handshake and result
interface wb_mux_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              err_count;

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid, err_count
    );

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid, err_count
    );
endinterface

// File: rtl/wb_mux_pipe.sv
// rtl/wb_mux_pipe.sv - registered N-way writeback select with two-slot skid stage
module wb_mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic          clk,
    input  logic          rst_f,
    wb_mux_pipe_if.slave  bus
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
    logic             main_err_q, main_err_d, skid_err_q, skid_err_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] ent_data;
    logic             ent_err;
    logic             accept, consume;

    // Out-of-range selects yield a zero entry flagged as an error.
    always_comb begin
        ent_err  = int'(bus.sel) >= NUM_IN;
        ent_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(bus.sel) == i) ent_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    assign accept  = bus.in_valid & in_ready_q;
    assign consume = out_valid_q & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        err_cnt_d   = err_cnt_q;

        // The error count sees accepts even in a flush cycle.
        if (accept && ent_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

        if (bus.flush) begin
            state_d     = S_EMPTY;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_data_d = ent_data;
                        main_sel_d  = bus.sel;
                        main_err_d  = ent_err;
                        state_d     = S_ONE;
                        out_valid_d = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && consume) begin
                        main_data_d = ent_data;
                        main_sel_d  = bus.sel;
                        main_err_d  = ent_err;
                    end else if (accept) begin
                        skid_data_d = ent_data;
                        skid_sel_d  = bus.sel;
                        skid_err_d  = ent_err;
                        state_d     = S_TWO;
                        in_ready_d  = 1'b0;
                    end else if (consume) begin
                        state_d     = S_EMPTY;
                        out_valid_d = 1'b0;
                    end
                end
                S_TWO: begin
                    if (consume) begin
                        main_data_d = skid_data_q;
                        main_sel_d  = skid_sel_q;
                        main_err_d  = skid_err_q;
                        state_d     = S_ONE;
                        in_ready_d  = 1'b1;
                    end
                end
                default: begin
                    state_d     = S_EMPTY;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.out_data  = main_data_q;
    assign bus.out_sel   = main_sel_q;
    assign bus.out_err   = main_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.err_count = err_cnt_q;
endmodule
